// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data and one-cycle overflow/underflow pulses.
// Occupancy is tracked with wrap-bit pointers so full and empty decode without a counter.
module async_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             overflow,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;

    // Flags come straight from the registered pointers.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        rd_ok = rd_en && !empty;
        wr_ok = wr_en && (!full || rd_ok);
    end

    // Storage is not reset; writes are held off while rst is high.
    always_ff @(posedge wr_clk) begin
        if (!rst && wr_ok) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            rdata     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_ok) begin
                rptr  <= rptr + PW'(1);
                rdata <= mem[rptr[AW-1:0]];
            end
            overflow  <= wr_en && full && !rd_ok;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, fill/drain, error pulses, simultaneous access,
// mid-operation reset and a randomised wrap-around run against a reference queue.
module tb_async_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic             wr_clk = 1'b0;
    logic             rst    = 1'b1;
    logic             wr_en  = 1'b0;
    logic [WIDTH-1:0] wdata  = '0;
    logic             full;
    logic             overflow;
    logic             rd_en  = 1'b0;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             underflow;

    int n_vec = 0;
    int n_err = 0;

    async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .full      (full),
        .overflow  (overflow),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .empty     (empty),
        .underflow (underflow)
    );

    always #5 wr_clk = ~wr_clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    endtask

    task automatic test_fill_overflow_drain();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(i);
            tick();
            n_vec++; if (full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 15); end
            n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
        end
        wr_en = 1'b1; wdata = 8'hAA;
        tick();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_pulse got=%b exp=1", overflow); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL overflow_full got=%b exp=1", full); end
        wr_en = 1'b0;
        tick();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL overflow_still_full got=%b exp=1", full); end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_vec++; if (rdata !== 8'(i)) begin n_err++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, rdata, 8'(i)); end
            n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
            n_vec++; if (empty !== (i == 15)) begin n_err++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, i == 15); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL underflow_pulse got=%b exp=1", underflow); end
        n_vec++; if (rdata !== 8'h0F) begin n_err++; $display("FAIL underflow_rdata_hold got=%h exp=0f", rdata); end
        tick();
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL underflow_back_to_back got=%b exp=1", underflow); end
        rd_en = 1'b0;
        tick();
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL underflow_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simul_mid();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h20 + i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h25 + i);
            tick();
            n_vec++; if (rdata !== 8'(8'h20 + i)) begin n_err++; $display("FAIL mid_rdata[%0d] got=%h exp=%h", i, rdata, 8'(8'h20 + i)); end
            n_vec++; if ({overflow, underflow, empty, full} !== 4'b0000) begin n_err++; $display("FAIL mid_flags[%0d] got=%b exp=0000", i, {overflow, underflow, empty, full}); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
            n_vec++; if (rdata !== 8'(8'h2A + i)) begin n_err++; $display("FAIL mid_drain[%0d] got=%h exp=%h", i, rdata, 8'(8'h2A + i)); end
            n_vec++; if (empty !== (i == 4)) begin n_err++; $display("FAIL mid_count[%0d] empty got=%b exp=%b", i, empty, i == 4); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h40 + i);
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h99;
        tick();
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_rw_full got=%b exp=1", full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_rw_overflow got=%b exp=0", overflow); end
        n_vec++; if (rdata !== 8'h40) begin n_err++; $display("FAIL full_rw_rdata got=%h exp=40", rdata); end
        wr_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_vec++; if (rdata !== ((i == 16) ? 8'h99 : 8'(8'h40 + i))) begin n_err++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, rdata, (i == 16) ? 8'h99 : 8'(8'h40 + i)); end
        end
        rd_en = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_rw_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simul_empty();
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h77;
        tick();
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL empty_rw_underflow got=%b exp=1", underflow); end
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL empty_rw_empty got=%b exp=0", empty); end
        n_vec++; if (rdata !== 8'h99) begin n_err++; $display("FAIL empty_rw_rdata_hold got=%h exp=99", rdata); end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        n_vec++; if (rdata !== 8'h77) begin n_err++; $display("FAIL empty_rw_readback got=%h exp=77", rdata); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL empty_rw_underflow_clear got=%b exp=0", underflow); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL empty_rw_final_empty got=%b exp=1", empty); end
        rd_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h50 + i);
            tick();
        end
        rd_en = 1'b1;
        tick();
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        n_vec++; if ({empty, full, overflow, underflow} !== 4'b1000) begin n_err++; $display("FAIL midrst_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
        n_vec++; if (rdata !== 8'h00) begin n_err++; $display("FAIL midrst_rdata got=%h exp=00", rdata); end
        rd_en = 1'b1;
        tick();
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL midrst_discard got=%b exp=1", underflow); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap_random();
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] exp;
        int writes = 0;
        int reads  = 0;
        int cycles = 0;
        int cnt;
        bit we, re, wr_acc, rd_acc;
        while ((writes < 40 || reads < 40) && cycles < 600) begin
            we = (writes < 40) && ($urandom_range(2) != 0);
            re = (writes >= 40) ? 1'b1 : ($urandom_range(1) == 1);
            wr_en = we; rd_en = re; wdata = 8'($urandom);
            cnt = q.size();
            rd_acc = re && (cnt > 0);
            wr_acc = we && ((cnt < 16) || rd_acc);
            exp = '0;
            if (rd_acc) exp = q.pop_front();
            if (wr_acc) q.push_back(wdata);
            tick();
            cycles++;
            if (wr_acc) writes++;
            if (rd_acc) begin
                reads++;
                n_vec++; if (rdata !== exp) begin n_err++; $display("FAIL wrap_rdata[%0d] got=%h exp=%h", reads, rdata, exp); end
            end
            n_vec++; if (overflow !== (we && cnt == 16 && !rd_acc)) begin n_err++; $display("FAIL wrap_overflow[%0d] got=%b exp=%b", cycles, overflow, we && cnt == 16 && !rd_acc); end
            n_vec++; if (underflow !== (re && cnt == 0)) begin n_err++; $display("FAIL wrap_underflow[%0d] got=%b exp=%b", cycles, underflow, re && cnt == 0); end
            n_vec++; if ({empty, full} !== {q.size() == 0, q.size() == 16}) begin n_err++; $display("FAIL wrap_flags[%0d] got=%b%b exp=%b%b", cycles, empty, full, q.size() == 0, q.size() == 16); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++; if (reads !== 40) begin n_err++; $display("FAIL wrap_budget got=%0d reads exp=40", reads); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow_drain();
        test_underflow();
        test_simul_mid();
        test_simul_full();
        test_simul_empty();
        test_mid_reset();
        test_wrap_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
